frac_n_divider_mash: RTL and testbench

//  Parametrised fractional-N loop divider. Integer modulus counter plus runtime-selectable MASH 1 / 1-1 / 1-1-1

---
 rtl/frac_n_divider_mash.sv | 147 ++++++++++++++
 tb/tb_frac_n_divider_mash.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_n_divider_mash.sv
// Fractional-N loop divider: down-counting modulus counter driven by a MASH 1 / 1-1 / 1-1-1
// sigma-delta modulator with optional LFSR dither; configuration is double-buffered per period.
module frac_n_divider_mash #(
  parameter int N_W     = 6,
  parameter int F_W     = 16,
  parameter int N_RST   = 30,
  parameter int MIN_DIV = 4,
  parameter int MAX_DIV = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_W-1:0]      n_int,
  input  logic [F_W-1:0]      frac,
  input  logic [1:0]          order_sel,
  input  logic                dither_en,
  input  logic                cfg_load,
  output logic                cfg_busy,
  output logic                div_pulse,
  output logic [N_W:0]        div_ratio,
  output logic signed [3:0]   sdm_qn,
  output logic                clamp_flag
);

  localparam int R_W = N_W + 1;
  localparam int S_W = N_W + 2;
  localparam logic signed [S_W-1:0] MIN_S = S_W'(MIN_DIV);
  localparam logic signed [S_W-1:0] MAX_S = S_W'(MAX_DIV);

  function automatic logic needs_clamp(input logic signed [S_W-1:0] r);
    return (r < MIN_S) || (r > MAX_S);
  endfunction

  function automatic logic [R_W-1:0] sat_ratio(input logic signed [S_W-1:0] r);
    if (r < MIN_S)      return R_W'(MIN_DIV);
    else if (r > MAX_S) return R_W'(MAX_DIV);
    else                return r[R_W-1:0];
  endfunction

  logic [R_W-1:0] count;
  logic [N_W-1:0] n_act, n_sh;
  logic [F_W-1:0] frac_act, frac_sh;
  logic [1:0]     order_act, order_sh;
  logic           dither_act, dither_sh;
  logic [F_W-1:0] a1, a2, a3;
  logic           c2_d, c3_d, c3_dd;
  logic [15:0]    lfsr;

  logic                  dith;
  logic [F_W:0]          s1, s2, s3;
  logic                  c1, c2, c3;
  logic signed [3:0]     qn_next;
  logic signed [S_W-1:0] ratio_sum;
  logic [R_W-1:0]        ratio_next;
  logic                  ord_change;

  assign div_pulse = (count == '0);

  always_comb begin
    dith      = dither_act && (order_act != 2'd0) && lfsr[0];
    s1        = {1'b0, a1} + {1'b0, frac_act} + {{F_W{1'b0}}, dith};
    s2        = {1'b0, a2} + {1'b0, s1[F_W-1:0]};
    s3        = {1'b0, a3} + {1'b0, s2[F_W-1:0]};
    // Stages above the selected order contribute no carry.
    c1        = s1[F_W] && (order_act >= 2'd1);
    c2        = s2[F_W] && (order_act >= 2'd2);
    c3        = s3[F_W] && (order_act == 2'd3);
    qn_next   = $signed({3'b000, c1}) + $signed({3'b000, c2}) - $signed({3'b000, c2_d})
              + $signed({3'b000, c3}) - $signed({2'b00, c3_d, 1'b0}) + $signed({3'b000, c3_dd});
    ratio_sum = $signed({2'b00, n_act}) + $signed({{(S_W-4){qn_next[3]}}, qn_next});
    ratio_next = sat_ratio(ratio_sum);
    ord_change = cfg_busy && (order_sh != order_act);
  end

  // Counter, shadow/active configuration and period outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= R_W'(N_RST - 1);
      div_ratio  <= R_W'(N_RST);
      sdm_qn     <= '0;
      clamp_flag <= 1'b0;
      cfg_busy   <= 1'b0;
      n_act      <= N_W'(N_RST);
      frac_act   <= '0;
      order_act  <= '0;
      dither_act <= 1'b0;
      n_sh       <= N_W'(N_RST);
      frac_sh    <= '0;
      order_sh   <= '0;
      dither_sh  <= 1'b0;
    end else begin
      if (cfg_load) begin
        n_sh      <= n_int;
        frac_sh   <= frac;
        order_sh  <= order_sel;
        dither_sh <= dither_en;
      end
      if (cfg_load)       cfg_busy <= 1'b1;
      else if (div_pulse) cfg_busy <= 1'b0;
      if (div_pulse) begin
        count     <= ratio_next - 1'b1;
        div_ratio <= ratio_next;
        sdm_qn    <= qn_next;
        if (needs_clamp(ratio_sum)) clamp_flag <= 1'b1;
        // The SDM above used the old active config; the shadow drives the next update.
        if (cfg_busy) begin
          n_act      <= n_sh;
          frac_act   <= frac_sh;
          order_act  <= order_sh;
          dither_act <= dither_sh;
        end
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  // Modulator state, advanced once per division period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1    <= '0;
      a2    <= '0;
      a3    <= '0;
      c2_d  <= 1'b0;
      c3_d  <= 1'b0;
      c3_dd <= 1'b0;
      lfsr  <= 16'hACE1;
    end else if (div_pulse) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (ord_change) begin
        a1    <= '0;
        a2    <= '0;
        a3    <= '0;
        c2_d  <= 1'b0;
        c3_d  <= 1'b0;
        c3_dd <= 1'b0;
      end else begin
        a1    <= (order_act >= 2'd1) ? s1[F_W-1:0] : '0;
        a2    <= (order_act >= 2'd2) ? s2[F_W-1:0] : '0;
        a3    <= (order_act == 2'd3) ? s3[F_W-1:0] : '0;
        c2_d  <= c2;
        c3_d  <= c3;
        c3_dd <= c3_d;
      end
    end
  end

endmodule

// File: tb/tb_frac_n_divider_mash.sv
// Bench for frac_n_divider_mash: period-level reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized configuration phase.
module tb_frac_n_divider_mash;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [5:0]        n_int = 6'd30;
  logic [15:0]       frac = '0;
  logic [1:0]        order_sel = '0;
  logic              dither_en = 1'b0;
  logic              cfg_load = 1'b0;
  logic              cfg_busy, div_pulse, clamp_flag;
  logic [6:0]        div_ratio;
  logic signed [3:0] sdm_qn;

  int checks = 0;
  int errors = 0;

  frac_n_divider_mash dut (
    .clk(clk), .rst(rst), .n_int(n_int), .frac(frac), .order_sel(order_sel),
    .dither_en(dither_en), .cfg_load(cfg_load), .cfg_busy(cfg_busy), .div_pulse(div_pulse),
    .div_ratio(div_ratio), .sdm_qn(sdm_qn), .clamp_flag(clamp_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=[%0d..%0d]", name, $time, act, lo, hi);
    end
  endtask

  // Reference model: cycle position within the period plus the modulator as integer arithmetic.
  int m_cyc, m_ratio, m_qn;
  bit m_busy, m_clamp;
  int m_n, m_frac, m_ord, m_dith;
  int s_n, s_frac, s_ord, s_dith;
  int a1, a2, a3, c2d, c3d, c3dd;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_cyc = 0; m_ratio = 30; m_qn = 0; m_busy = 0; m_clamp = 0;
    m_n = 30; m_frac = 0; m_ord = 0; m_dith = 0;
    s_n = 30; s_frac = 0; s_ord = 0; s_dith = 0;
    a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d = 0; c3dd = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    int d, c1, c2, c3, qn, r;
    if (m_cyc == m_ratio - 1) begin
      d = (m_dith != 0 && m_ord > 0) ? int'(m_lfsr[0]) : 0;
      c1 = 0; c2 = 0; c3 = 0;
      if (m_ord > 0) begin
        a1 = a1 + m_frac + d; c1 = a1 / 65536; a1 = a1 % 65536;
        a2 = a2 + a1;         c2 = a2 / 65536; a2 = a2 % 65536;
        a3 = a3 + a2;         c3 = a3 / 65536; a3 = a3 % 65536;
        if (m_ord < 2) c2 = 0;
        if (m_ord < 3) c3 = 0;
      end
      qn = c1 + (c2 - c2d) + (c3 - 2 * c3d + c3dd);
      c3dd = c3d; c3d = c3; c2d = c2;
      r = m_n + qn;
      if (r < 4)  begin r = 4;  m_clamp = 1; end
      if (r > 63) begin r = 63; m_clamp = 1; end
      m_ratio = r; m_qn = qn;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      if (m_busy) begin
        if (s_ord != m_ord) begin
          a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d = 0; c3dd = 0;
        end
        m_n = s_n; m_frac = s_frac; m_ord = s_ord; m_dith = s_dith;
        m_busy = 0;
      end
      m_cyc = 0;
    end else begin
      m_cyc++;
    end
    if (cfg_load) begin
      s_n = int'(n_int); s_frac = int'(frac); s_ord = int'(order_sel); s_dith = int'(dither_en);
      m_busy = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    logic [13:0] act_v, exp_v;
    logic        e_pulse;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_pulse = (m_cyc == m_ratio - 1);
        act_v = {div_pulse, div_ratio, sdm_qn, cfg_busy, clamp_flag};
        exp_v = {e_pulse, 7'(m_ratio), 4'(m_qn), m_busy, m_clamp};
        check("cycle_compare", int'(act_v), int'(exp_v));
      end
    end
  end

  task automatic wait_pulse(output int len);
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (!div_pulse && len < 300);
    if (!div_pulse) check("pulse_timeout", int'(div_pulse), 1);
  endtask

  task automatic load_cfg(input int n, input int f, input int o, input int d);
    n_int = 6'(n); frac = 16'(f); order_sel = 2'(o); dither_en = d[0];
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  initial begin
    int len, sum, qmin, qmax, rmin, rmax;
    int t2_len[6] = '{31, 30, 31, 30, 31, 30};
    int t2_qn[6]  = '{1, 0, 1, 0, 1, 0};

    // T1: reset values and default integer periods
    repeat (3) @(negedge clk);
    check("rst_div_pulse", int'(div_pulse), 0);
    check("rst_div_ratio", int'(div_ratio), 30);
    check("rst_sdm_qn", int'(sdm_qn), 0);
    check("rst_cfg_busy", int'(cfg_busy), 0);
    check("rst_clamp", int'(clamp_flag), 0);
    rst = 1'b0;
    wait_pulse(len);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(len);
      check("t1_period_len", len, 30);
      check("t1_div_ratio", int'(div_ratio), 30);
      check("t1_qn", int'(sdm_qn), 0);
    end

    // T2: MASH1 at one half alternates 30/31
    @(negedge clk);
    load_cfg(30, 16'h8000, 1, 0);
    check("t2_busy_after_load", int'(cfg_busy), 1);
    repeat (3) wait_pulse(len);
    for (int i = 0; i < 6; i++) begin
      wait_pulse(len);
      check("t2_period_len", len, t2_len[i]);
      check("t2_div_ratio", int'(div_ratio), t2_len[i]);
      check("t2_qn", int'(sdm_qn), t2_qn[i]);
    end

    // T3: MASH1-1-1 at one quarter, long-run mean
    @(negedge clk);
    load_cfg(30, 16'h4000, 3, 0);
    repeat (2) wait_pulse(len);
    sum = 0; qmin = 100; qmax = -100;
    for (int i = 0; i < 1024; i++) begin
      wait_pulse(len);
      sum += len;
      if (int'(sdm_qn) < qmin) qmin = int'(sdm_qn);
      if (int'(sdm_qn) > qmax) qmax = int'(sdm_qn);
    end
    check_range("t3_sum", sum, 30976 - 3, 30976 + 3);
    check_range("t3_qn_min", qmin, -3, 4);
    check_range("t3_qn_max", qmax, -3, 4);
    check("t3_no_clamp", int'(clamp_flag), 0);

    // T4: load mid-period takes effect on the period after next
    @(negedge clk);
    load_cfg(30, 0, 0, 0);
    repeat (3) wait_pulse(len);
    repeat (5) @(negedge clk);
    load_cfg(20, 0, 0, 0);
    check("t4_busy_set", int'(cfg_busy), 1);
    wait_pulse(len);
    check("t4_current_len", 6 + len, 30);
    check("t4_busy_until_pulse", int'(cfg_busy), 1);
    wait_pulse(len);
    check("t4_next_len", len, 30);
    check("t4_busy_cleared", int'(cfg_busy), 0);
    wait_pulse(len);
    check("t4_after_next_len", len, 20);
    check("t4_after_next_ratio", int'(div_ratio), 20);

    // T5: low modulus with MASH1-1-1 hits the clamp floor
    @(negedge clk);
    load_cfg(4, 16'h1234, 3, 0);
    repeat (2) wait_pulse(len);
    rmin = 1000; rmax = -1;
    for (int i = 0; i < 500; i++) begin
      wait_pulse(len);
      if (int'(div_ratio) < rmin) rmin = int'(div_ratio);
      if (int'(div_ratio) > rmax) rmax = int'(div_ratio);
    end
    check_range("t5_ratio_min", rmin, 4, 63);
    check_range("t5_ratio_max", rmax, 4, 63);
    check("t5_clamp_set", int'(clamp_flag), 1);

    // T6: asynchronous reset in the middle of a MASH1-1-1 period
    @(negedge clk);
    load_cfg(30, 16'h4000, 3, 1);
    repeat (3) wait_pulse(len);
    check("t6_clamp_sticky", int'(clamp_flag), 1);
    repeat (7) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_pulse", int'(div_pulse), 0);
    check("t6_rst_ratio", int'(div_ratio), 30);
    check("t6_rst_qn", int'(sdm_qn), 0);
    check("t6_rst_clamp", int'(clamp_flag), 0);
    check("t6_rst_busy", int'(cfg_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(len);
    for (int i = 0; i < 2; i++) begin
      wait_pulse(len);
      check("t6_period_len", len, 30);
    end

    // Randomized configurations, including back-to-back loads and loads on pulse cycles
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(1, 60)) @(negedge clk);
      load_cfg(int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end
    repeat (300) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
